// File: rtl/pulp_cluster_package.sv
// Shared cluster definitions: EOC peripheral register map, CNT_CTRL bit positions
// and the registered response record of the EOC slave.
package pulp_cluster_package;

  localparam logic [2:0] EOC_STATUS_OFFS  = 3'd0;
  localparam logic [2:0] EOC_CLEAR_OFFS   = 3'd1;
  localparam logic [2:0] FETCH_EN_OFFS    = 3'd2;
  localparam logic [2:0] CYCLE_CNT_OFFS   = 3'd3;
  localparam logic [2:0] CNT_CTRL_OFFS    = 3'd4;
  localparam logic [2:0] CLUSTER_EOC_OFFS = 3'd5;

  localparam int CNT_CTRL_EN_BIT  = 0;
  localparam int CNT_CTRL_CLR_BIT = 1;

  // The ID field is sized for the widest supported ID; the slave uses the low bits.
  localparam int RESP_ID_W = 32;

  typedef struct packed {
    logic                 valid;
    logic                 opc;
    logic [RESP_ID_W-1:0] id;
    logic [31:0]          rdata;
  } eoc_resp_t;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/cluster_cycle_counter.sv
// Free-running 32-bit benchmark counter with enable and synchronous clear.
// Clear takes priority over increment; the counter wraps silently.
module cluster_cycle_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        clr_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  assign cnt_d = clr_i ? 32'd0 : (en_i ? cnt_q + 32'd1 : cnt_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= 32'd0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cluster_eoc_periph_slave.sv
// End-of-computation register slave on the cluster peripheral interconnect.
// Always grants; answers every request with a single-cycle registered response.
module cluster_eoc_periph_slave
  import pulp_cluster_package::*;
#(
  parameter int                  NB_CORES     = 8,
  parameter int                  ID_WIDTH     = 5,
  parameter logic [NB_CORES-1:0] FETCH_EN_RST = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic [31:0]         add_i,
  input  logic                wen_i,
  input  logic [31:0]         wdata_i,
  input  logic [3:0]          be_i,
  input  logic [ID_WIDTH-1:0] id_i,
  output logic                gnt_o,
  output logic                r_valid_o,
  output logic                r_opc_o,
  output logic [ID_WIDTH-1:0] r_id_o,
  output logic [31:0]         r_rdata_o,
  input  logic [NB_CORES-1:0] core_eoc_i,
  output logic [NB_CORES-1:0] fetch_en_o,
  output logic                eoc_o
);

  logic [2:0]          offs;
  logic                mapped;
  logic                wr;
  logic                rd;
  logic [31:0]         bmask;
  logic [NB_CORES-1:0] eoc_status_q;
  logic [NB_CORES-1:0] eoc_clr_mask;
  logic [NB_CORES-1:0] fetch_en_q;
  logic                cnt_en_q;
  logic                cnt_clr;
  logic                cluster_eoc_q;
  logic [31:0]         cnt_val;
  logic [31:0]         rdata_mux;
  eoc_resp_t           resp_d;
  eoc_resp_t           resp_q;

  assign offs   = add_i[4:2];
  assign mapped = (offs <= CLUSTER_EOC_OFFS);
  assign gnt_o  = req_i;
  assign wr     = req_i & ~wen_i & mapped;
  assign rd     = req_i &  wen_i & mapped;
  assign bmask  = be_to_mask(be_i);

  assign eoc_clr_mask = (wr && offs == EOC_CLEAR_OFFS) ?
                        (wdata_i[NB_CORES-1:0] & bmask[NB_CORES-1:0]) : '0;
  assign cnt_clr      = wr && (offs == CNT_CTRL_OFFS) && be_i[0] && wdata_i[CNT_CTRL_CLR_BIT];

  // Incoming EOC is OR-ed in after the clear, so a simultaneous set survives.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) eoc_status_q <= '0;
    else       eoc_status_q <= (eoc_status_q & ~eoc_clr_mask) | core_eoc_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_en_q    <= FETCH_EN_RST;
      cnt_en_q      <= 1'b0;
      cluster_eoc_q <= 1'b0;
    end else if (wr) begin
      case (offs)
        FETCH_EN_OFFS:
          fetch_en_q <= (fetch_en_q & ~bmask[NB_CORES-1:0]) |
                        (wdata_i[NB_CORES-1:0] & bmask[NB_CORES-1:0]);
        CNT_CTRL_OFFS:
          if (be_i[0]) cnt_en_q <= wdata_i[CNT_CTRL_EN_BIT];
        CLUSTER_EOC_OFFS:
          if (be_i[0]) cluster_eoc_q <= wdata_i[0];
        default: ;
      endcase
    end
  end

  // The counter sees the old enable, so a newly written enable counts from the next cycle.
  cluster_cycle_counter u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (cnt_en_q),
    .clr_i (cnt_clr),
    .cnt_o (cnt_val)
  );

  always_comb begin
    rdata_mux = '0;
    case (offs)
      EOC_STATUS_OFFS:  rdata_mux = 32'(eoc_status_q);
      FETCH_EN_OFFS:    rdata_mux = 32'(fetch_en_q);
      CYCLE_CNT_OFFS:   rdata_mux = cnt_val;
      CNT_CTRL_OFFS:    rdata_mux[CNT_CTRL_EN_BIT] = cnt_en_q;
      CLUSTER_EOC_OFFS: rdata_mux[0] = cluster_eoc_q;
      default: ;
    endcase
  end

  always_comb begin
    resp_d       = '0;
    resp_d.valid = req_i;
    resp_d.opc   = req_i & ~mapped;
    resp_d.id    = req_i ? RESP_ID_W'(id_i) : resp_q.id;
    resp_d.rdata = rd ? rdata_mux : 32'd0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) resp_q <= '0;
    else       resp_q <= resp_d;
  end

  assign r_valid_o  = resp_q.valid;
  assign r_opc_o    = resp_q.opc;
  assign r_id_o     = resp_q.id[ID_WIDTH-1:0];
  assign r_rdata_o  = resp_q.rdata;
  assign fetch_en_o = fetch_en_q;
  assign eoc_o      = cluster_eoc_q;

  logic unused_bits;
  assign unused_bits = ^{add_i[31:5], add_i[1:0], wdata_i, resp_q.id};

endmodule

// File: tb/tb_cluster_eoc_periph_slave.sv
// Directed bench for the cluster EOC peripheral slave: register map, byte enables,
// sticky EOC with clear, cycle counter incl. wrap, unmapped offsets and async reset.
module tb_cluster_eoc_periph_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [4:0]  id;
  logic        gnt;
  logic        r_valid;
  logic        r_opc;
  logic [4:0]  r_id;
  logic [31:0] r_rdata;
  logic [7:0]  core_eoc;
  logic [7:0]  fetch_en;
  logic        eoc;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cluster_eoc_periph_slave #(.NB_CORES(8), .ID_WIDTH(5), .FETCH_EN_RST(8'h00)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .add_i      (add),
    .wen_i      (wen),
    .wdata_i    (wdata),
    .be_i       (be),
    .id_i       (id),
    .gnt_o      (gnt),
    .r_valid_o  (r_valid),
    .r_opc_o    (r_opc),
    .r_id_o     (r_id),
    .r_rdata_o  (r_rdata),
    .core_eoc_i (core_eoc),
    .fetch_en_o (fetch_en),
    .eoc_o      (eoc)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One request presented across a single rising edge; returns 1 time unit after it.
  task automatic xfer(input logic rd_n, input logic [2:0] o, input logic [31:0] wd,
                      input logic [3:0] b, input logic [4:0] i);
    @(negedge clk);
    req = 1'b1; wen = rd_n; add = {27'd0, o, 2'b00}; wdata = wd; be = b; id = i;
    #1 check("gnt", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] o, input logic [4:0] i,
                        input logic [31:0] exp);
    xfer(1'b1, o, 32'd0, 4'h0, i);
    check({tag, ".valid"}, 32'(r_valid), 32'd1);
    check({tag, ".opc"}, 32'(r_opc), 32'd0);
    check({tag, ".id"}, 32'(r_id), 32'(i));
    check({tag, ".rdata"}, r_rdata, exp);
  endtask

  task automatic wr(input string tag, input logic [2:0] o, input logic [31:0] d,
                    input logic [3:0] b);
    xfer(1'b0, o, d, b, 5'd9);
    check({tag, ".valid"}, 32'(r_valid), 32'd1);
    check({tag, ".opc"}, 32'(r_opc), 32'd0);
    check({tag, ".rdata"}, r_rdata, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; add = '0; wen = 1'b1; wdata = '0; be = '0; id = '0;
    core_eoc = '0;
    #1;
    check("rst.valid", 32'(r_valid), 32'd0);
    check("rst.rdata", r_rdata, 32'd0);
    check("rst.id", 32'(r_id), 32'd0);
    check("rst.fetch_en", 32'(fetch_en), 32'd0);
    check("rst.eoc", 32'(eoc), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // reset contents of every mapped offset
    rd_chk("r0_status", 3'd0, 5'd1, 32'd0);
    rd_chk("r1_clear", 3'd1, 5'd2, 32'd0);
    rd_chk("r2_fetch", 3'd2, 5'd3, 32'd0);
    rd_chk("r3_cnt", 3'd3, 5'd4, 32'd0);
    rd_chk("r4_ctrl", 3'd4, 5'd5, 32'd0);
    rd_chk("r5_ceoc", 3'd5, 5'd6, 32'd0);

    // byte enables: only byte 0 lands, byte 1 lies beyond the 8-bit register
    wr("w_fetch", 3'd2, 32'hFFFF_FFFF, 4'b0001);
    check("fetch_en_o", 32'(fetch_en), 32'h0000_00FF);
    rd_chk("rb_fetch", 3'd2, 5'd7, 32'h0000_00FF);
    wr("w_fetch_b1", 3'd2, 32'h0000_0000, 4'b0010);
    check("fetch_en_b1", 32'(fetch_en), 32'h0000_00FF);
    wr("w_fetch_5a", 3'd2, 32'h1234_565A, 4'b0001);
    rd_chk("rb_fetch5a", 3'd2, 5'd8, 32'h0000_005A);

    // sticky EOC, set wins over a simultaneous clear
    @(negedge clk) core_eoc = 8'h01;
    @(negedge clk) core_eoc = 8'h00;
    rd_chk("st_sticky", 3'd0, 5'd10, 32'h0000_0001);
    core_eoc = 8'h08;
    wr("w_clr_set", 3'd1, 32'h0000_0008, 4'hF);
    core_eoc = 8'h00;
    rd_chk("st_setwins", 3'd0, 5'd11, 32'h0000_0009);
    wr("w_clr8", 3'd1, 32'h0000_0008, 4'hF);
    rd_chk("st_clr8", 3'd0, 5'd12, 32'h0000_0001);
    wr("w_clr1", 3'd1, 32'h0000_0001, 4'hF);
    rd_chk("st_zero", 3'd0, 5'd13, 32'h0000_0000);
    rd_chk("rd_clrreg", 3'd1, 5'd14, 32'h0000_0000);

    // counter: enable effective next cycle; clear wins and restarts from 0
    wr("w_cnt_en", 3'd4, 32'h0000_0001, 4'hF);
    repeat (10) @(posedge clk);
    rd_chk("cnt_10", 3'd3, 5'd15, 32'd10);
    wr("w_cnt_clr", 3'd4, 32'h0000_0003, 4'hF);
    rd_chk("cnt_after_clr", 3'd3, 5'd16, 32'd0);
    rd_chk("cnt_after_clr1", 3'd3, 5'd17, 32'd1);
    rd_chk("ctrl_rb", 3'd4, 5'd18, 32'd1);

    // preload near the top and watch the wrap
    @(negedge clk) force dut.u_cnt.cnt_d = 32'hFFFF_FFFE;
    @(posedge clk); #1 release dut.u_cnt.cnt_d;
    rd_chk("wrap_fe", 3'd3, 5'd19, 32'hFFFF_FFFE);
    rd_chk("wrap_ff", 3'd3, 5'd20, 32'hFFFF_FFFF);
    rd_chk("wrap_00", 3'd3, 5'd21, 32'h0000_0000);

    // cluster EOC output
    wr("w_ceoc", 3'd5, 32'h0000_0001, 4'h1);
    check("eoc_o", 32'(eoc), 32'd1);
    rd_chk("rb_ceoc", 3'd5, 5'd22, 32'd1);

    // unmapped offsets back to back, then idle
    xfer(1'b1, 3'd6, 32'd0, 4'h0, 5'd5);
    check("um6.valid", 32'(r_valid), 32'd1);
    check("um6.opc", 32'(r_opc), 32'd1);
    check("um6.rdata", r_rdata, 32'd0);
    check("um6.id", 32'(r_id), 32'd5);
    xfer(1'b1, 3'd7, 32'd0, 4'h0, 5'd6);
    check("um7.valid", 32'(r_valid), 32'd1);
    check("um7.opc", 32'(r_opc), 32'd1);
    check("um7.rdata", r_rdata, 32'd0);
    check("um7.id", 32'(r_id), 32'd6);
    xfer(1'b0, 3'd6, 32'hFFFF_FFFF, 4'hF, 5'd7);
    check("um6w.opc", 32'(r_opc), 32'd1);
    check("um6w.rdata", r_rdata, 32'd0);
    @(posedge clk); #1;
    check("idle.valid", 32'(r_valid), 32'd0);
    rd_chk("ceoc_kept", 3'd5, 5'd23, 32'd1);

    // async reset with a request pending
    @(negedge clk);
    req = 1'b1; wen = 1'b1; add = 32'h0; id = 5'd3;
    #1 rst = 1'b1;
    #1;
    check("mid_rst.valid", 32'(r_valid), 32'd0);
    check("mid_rst.eoc", 32'(eoc), 32'd0);
    check("mid_rst.fetch", 32'(fetch_en), 32'd0);
    @(posedge clk);
    @(negedge clk) begin req = 1'b0; rst = 1'b0; end
    @(posedge clk); #1;
    check("post_rst.valid", 32'(r_valid), 32'd0);
    rd_chk("post_rst_cnt", 3'd3, 5'd24, 32'd0);
    rd_chk("post_rst_ctrl", 3'd4, 5'd25, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cluster_eoc_periph_slave.md
Name: cluster_eoc_periph_slave

Overview:
- Responder on the cluster peripheral interconnect slave plug at index SPER_EOC_ID.
- Answers word-wide read/write requests from the peripheral interconnect (initiator side) using the interconnect's req/gnt and r_valid protocol.
- Holds the end-of-computation (EOC) control and status registers: sticky per-core EOC flags, per-core fetch enables, the cluster EOC output, and a 32-bit cycle counter used for benchmarking.

Parameters:
- NB_CORES, 8, number of cores; sets the width of the EOC and fetch-enable vectors (1..32).
- ID_WIDTH, 5, width of the transaction ID, returned unchanged on r_id_o.
- FETCH_EN_RST, 0, reset value of the fetch-enable register (NB_CORES bits).

Ports:
- clk_i  in  1  cluster clock
- rst_i  in  1  asynchronous active-high reset
- req_i  in  1  request valid
- add_i  in  32  byte address; only bits [4:2] are decoded
- wen_i  in  1  1 = read, 0 = write
- wdata_i  in  32  write data
- be_i  in  4  byte enables for writes
- id_i  in  ID_WIDTH  transaction ID
- gnt_o  out  1  grant
- r_valid_o  out  1  response valid
- r_opc_o  out  1  response error (1 = unmapped offset)
- r_id_o  out  ID_WIDTH  response ID
- r_rdata_o  out  32  read data
- core_eoc_i  in  NB_CORES  per-core EOC pulse or level
- fetch_en_o  out  NB_CORES  per-core fetch enable
- eoc_o  out  1  cluster EOC to the SoC

Behaviour:
- Register map, offset = add_i[4:2]:
  - 0 EOC_STATUS: read-only, sticky OR of core_eoc_i.
  - 1 EOC_CLEAR: write-1-to-clear of EOC_STATUS; reads return 0.
  - 2 FETCH_EN: read/write, NB_CORES bits.
  - 3 CYCLE_CNT: read-only.
  - 4 CNT_CTRL: read/write; bit0 = enable; bit1 = clear, self-clearing, always reads 0.
  - 5 CLUSTER_EOC: read/write bit0, drives eoc_o.
  - 6 and 7: unmapped.
- Grant:
  - gnt_o = req_i, combinational.
  - No backpressure; every request is accepted in the cycle it is presented.
- Response:
  - Latency is exactly 1 cycle: r_valid_o is asserted in cycle N+1 for a request granted in cycle N.
  - r_id_o is id_i registered.
  - Back-to-back requests give back-to-back responses.
  - Deasserting req_i leaves r_valid_o at 0 in the following cycle.
- Reads: r_rdata_o is the register value sampled at the request cycle (before any same-cycle hardware update). Unused upper bits read as 0.
- Writes:
  - Byte enables gate each byte of RW registers; bits beyond the register width are ignored.
  - r_rdata_o = 0 on a write response.
- Unmapped offsets:
  - r_opc_o = 1 and r_rdata_o = 0.
  - No state changes.
  - r_opc_o = 0 for all mapped accesses.
- EOC_STATUS update:
  - next = (cur & ~clear_mask) | core_eoc_i.
  - A set in the same cycle as a clear wins.
- Cycle counter:
  - Increments by 1 per cycle while enable = 1.
  - Wraps from 0xFFFF_FFFF to 0 with no flag.
  - A clear write loads 0 that cycle and increments from the next cycle if enabled; clear wins over increment.
  - A write setting enable takes effect the next cycle.
- Reset values, asynchronous, applied immediately on rst_i:
  - r_valid_o = 0, r_opc_o = 0, r_id_o = 0, r_rdata_o = 0.
  - fetch_en_o = FETCH_EN_RST, eoc_o = 0, EOC_STATUS = 0, counter = 0, enable = 0.
- A request pending when reset asserts is dropped: no response is produced after reset releases.

Decomposition:
- pulp_cluster_package gains:
  - EOC register offset constants: EOC_STATUS_OFFS, EOC_CLEAR_OFFS, FETCH_EN_OFFS, CYCLE_CNT_OFFS, CNT_CTRL_OFFS, CLUSTER_EOC_OFFS.
  - CNT_CTRL bit-position constants.
  - A packed struct type for the registered response (valid, opc, id, rdata).
- One sub-module: cluster_cycle_counter (32-bit, enable, synchronous clear, asynchronous active-high reset).

Test Plan:
- Reset, then read all offsets 0..5 -> every read has r_valid_o one cycle later, EOC_STATUS = 0, FETCH_EN = FETCH_EN_RST, CYCLE_CNT = 0, r_opc_o = 0.
- Write FETCH_EN = 0xFFFF_FFFF with be_i = 4'b0001 -> fetch_en_o = 0xFF the next cycle; a read back returns 0x0000_00FF.
- Pulse core_eoc_i[3] and write EOC_CLEAR = 0x08 in the same cycle -> bit 3 stays set; a second clear write -> EOC_STATUS = 0.
- Write CNT_CTRL = 1, wait 10 cycles, read CYCLE_CNT -> value equals the cycle distance from the enable taking effect to the read request; write CNT_CTRL = 3 -> the next read returns a small count counted from 0.
- Force the counter to 0xFFFF_FFFE with enable = 1 -> it reads 0xFFFF_FFFF and then 0 on successive cycles (wrap).
- Read offset 6, then 7 back-to-back with IDs 5 and 6 -> two consecutive responses with r_opc_o = 1, r_rdata_o = 0, r_id_o = 5 then 6; assert rst_i mid-stream -> r_valid_o = 0 immediately and eoc_o = 0.
